// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared states, limits and frame-length helper for the UART RX timing path
package uart_rx_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int MIN_PRESCALE = 4;
  localparam int MAX_FRAME_BITS = 12;
  function automatic logic [3:0] frame_len(input logic [1:0] data_sel, input logic par_en, input logic stop2);
    return 4'd7 + {2'b0, data_sel} + {3'b0, par_en} + {3'b0, stop2};
  endfunction
endpackage

// File: rtl/uart_rx_bit_timer_if.sv
// uart_rx_bit_timer_if: configuration/enable in, counters and strobes out
interface uart_rx_bit_timer_if #(parameter int PRESCALE_W = 6, parameter int BIT_CNT_W = 4);
  logic                  enable;
  logic [PRESCALE_W-1:0] prescale;
  logic [1:0]            data_sel;
  logic                  par_en;
  logic                  stop2;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  sample_stb;
  logic [1:0]            sample_idx;
  logic                  bit_done;
  logic                  frame_done;
  logic                  cfg_err;
  modport master (output enable, prescale, data_sel, par_en, stop2,
                  input edge_cnt, bit_cnt, sample_stb, sample_idx, bit_done, frame_done, cfg_err);
  modport slave (input enable, prescale, data_sel, par_en, stop2,
                 output edge_cnt, bit_cnt, sample_stb, sample_idx, bit_done, frame_done, cfg_err);
endinterface

// File: rtl/uart_rx_sample_decode.sv
// uart_rx_sample_decode: flags the three majority-vote edges centred on mid-bit
module uart_rx_sample_decode #(parameter int W = 6) (
  input  logic [W-1:0] i_ps,
  input  logic [W-1:0] i_edge,
  output logic         o_stb,
  output logic [1:0]   o_idx
);
  logic [W-1:0] w_mid, w_lo, w_hi;
  assign w_mid = i_ps >> 1;
  assign w_lo  = w_mid - W'(1);
  assign w_hi  = w_mid + W'(1);
  // window membership and position within it
  always_comb begin
    o_stb = (i_edge == w_lo) || (i_edge == w_mid) || (i_edge == w_hi);
    o_idx = (i_edge == w_hi) ? 2'd2 : (i_edge == w_mid) ? 2'd1 : 2'd0;
  end
endmodule

// File: rtl/uart_rx_bit_timer.sv
// uart_rx_bit_timer: per-bit edge counter and per-frame bit counter with shadowed config
module uart_rx_bit_timer
  import uart_rx_pkg::*;
#(parameter int PRESCALE_W = 6, parameter int BIT_CNT_W = 4) (
  input logic clk,
  input logic rst,
  uart_rx_bit_timer_if.slave tmr
);
  state_t                r_state, w_state_n;
  logic [PRESCALE_W-1:0] r_edge_cnt, w_edge_n, r_ps_l, w_ps_n;
  logic [BIT_CNT_W-1:0]  r_bit_cnt, w_bit_n, r_n_l, w_n_n;
  logic                  r_cfg_err, w_err_n;
  logic                  w_legal, w_last_edge, w_last_bit, w_run, w_dec_stb;
  logic [1:0]            w_dec_idx;
  assign w_legal     = tmr.prescale >= PRESCALE_W'(MIN_PRESCALE);
  assign w_last_edge = r_edge_cnt == r_ps_l - PRESCALE_W'(1);
  assign w_last_bit  = r_bit_cnt == r_n_l - BIT_CNT_W'(1);
  assign w_run       = tmr.enable && r_state == RUN;
  uart_rx_sample_decode #(.W(PRESCALE_W)) u_dec (
    .i_ps  (r_ps_l),
    .i_edge(r_edge_cnt),
    .o_stb (w_dec_stb),
    .o_idx (w_dec_idx)
  );
  // state, counters, error flag and config shadows
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_cfg_err  <= 1'b0;
      r_ps_l     <= '0;
      r_n_l      <= '0;
    end else begin
      r_state    <= w_state_n;
      r_edge_cnt <= w_edge_n;
      r_bit_cnt  <= w_bit_n;
      r_cfg_err  <= w_err_n;
      r_ps_l     <= w_ps_n;
      r_n_l      <= w_n_n;
    end
  end
  // next state: shadow config on frame start, walk edges then bits, park in DONE
  always_comb begin
    w_state_n = r_state;
    w_edge_n  = r_edge_cnt;
    w_bit_n   = r_bit_cnt;
    w_err_n   = r_cfg_err;
    w_ps_n    = r_ps_l;
    w_n_n     = r_n_l;
    if (!tmr.enable) begin
      w_state_n = IDLE;
      w_edge_n  = '0;
      w_bit_n   = '0;
      w_err_n   = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_ps_n    = tmr.prescale;
          w_n_n     = BIT_CNT_W'(frame_len(tmr.data_sel, tmr.par_en, tmr.stop2));
          w_state_n = w_legal ? RUN : IDLE;
          w_edge_n  = w_legal ? PRESCALE_W'(1) : '0;
          w_bit_n   = '0;
          w_err_n   = !w_legal;
        end
        RUN: begin
          w_edge_n  = !w_last_edge ? r_edge_cnt + PRESCALE_W'(1) : w_last_bit ? r_edge_cnt : '0;
          w_bit_n   = (w_last_edge && !w_last_bit) ? r_bit_cnt + BIT_CNT_W'(1) : r_bit_cnt;
          w_state_n = (w_last_edge && w_last_bit) ? DONE : RUN;
        end
        default: ;
      endcase
    end
  end
  // strobes decoded from registered state only, silenced whenever enable is low
  always_comb begin
    tmr.edge_cnt   = r_edge_cnt;
    tmr.bit_cnt    = r_bit_cnt;
    tmr.cfg_err    = r_cfg_err;
    tmr.sample_stb = w_run && w_dec_stb;
    tmr.sample_idx = (w_run && w_dec_stb) ? w_dec_idx : 2'd0;
    tmr.bit_done   = w_run && w_last_edge && !w_last_bit;
    tmr.frame_done = w_run && w_last_edge && w_last_bit;
  end
endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// tb_uart_rx_bit_timer: directed frames with a timing-formula scoreboard
module tb_uart_rx_bit_timer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  typedef struct packed {
    logic [5:0] e;
    logic [3:0] b;
    logic       stb;
    logic [1:0] idx;
    logic       bd;
    logic       fd;
    logic       err;
  } exp_t;
  exp_t q[$];
  exp_t m_x;
  always #5 clk = ~clk;
  uart_rx_bit_timer_if #(.PRESCALE_W(6), .BIT_CNT_W(4)) tmr ();
  uart_rx_bit_timer #(.PRESCALE_W(6), .BIT_CNT_W(4)) dut (.clk(clk), .rst(rst), .tmr(tmr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // expected outputs j cycles after enable first rose (bit k edge e at j = k*ps + e)
  function automatic exp_t model(input int j, input int ps, input int n, input bit en);
    exp_t x;
    int mid, k, e;
    x = '0;
    mid = ps / 2;
    if (ps < 4) x.err = (j >= 1);
    else if (j > 0 && j < n * ps) begin
      k = j / ps;
      e = j % ps;
      x.e = 6'(e);
      x.b = 4'(k);
      if (en) begin
        x.stb = (e >= mid - 1) && (e <= mid + 1);
        x.idx = x.stb ? 2'(e - mid + 1) : 2'd0;
        x.bd  = (e == ps - 1) && (k < n - 1);
        x.fd  = (e == ps - 1) && (k == n - 1);
      end
    end else if (j > 0) begin
      x.e = 6'(ps - 1);
      x.b = 4'(n - 1);
    end
    return x;
  endfunction

  always @(negedge clk) if (q.size() != 0) begin
    m_x = q.pop_front();
    chk("edge_cnt", 32'(tmr.edge_cnt), 32'(m_x.e));
    chk("bit_cnt", 32'(tmr.bit_cnt), 32'(m_x.b));
    chk("sample_stb", 32'(tmr.sample_stb), 32'(m_x.stb));
    chk("sample_idx", 32'(tmr.sample_idx), 32'(m_x.idx));
    chk("bit_done", 32'(tmr.bit_done), 32'(m_x.bd));
    chk("frame_done", 32'(tmr.frame_done), 32'(m_x.fd));
    chk("cfg_err", 32'(tmr.cfg_err), 32'(m_x.err));
  end

  task automatic run(input int ps, input int ds, input int pe, input int s2, input int ncyc,
                     input int chg_at, input int chg_ps, input bit drop);
    int n;
    n = 7 + ds + pe + s2;
    for (int j = 0; j <= ncyc; j++) begin
      if (j == ncyc && !drop) break;
      @(posedge clk);
      #1;
      if (j == 0) begin
        tmr.prescale = 6'(ps);
        tmr.data_sel = 2'(ds);
        tmr.par_en   = pe[0];
        tmr.stop2    = s2[0];
        tmr.enable   = 1'b1;
      end
      if (j == chg_at) tmr.prescale = 6'(chg_ps);
      if (j == ncyc) tmr.enable = 1'b0;
      q.push_back(model(j, ps, n, j < ncyc));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      tmr.enable = 1'b0;
      q.push_back('0);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_edge"}, 32'(tmr.edge_cnt), 0);
    chk({tag, "_bit"}, 32'(tmr.bit_cnt), 0);
    chk({tag, "_stb"}, 32'(tmr.sample_stb), 0);
    chk({tag, "_bd"}, 32'(tmr.bit_done), 0);
    chk({tag, "_fd"}, 32'(tmr.frame_done), 0);
    chk({tag, "_err"}, 32'(tmr.cfg_err), 0);
  endtask

  initial begin
    tmr.enable = 1'b1;
    tmr.prescale = 6'd8;
    tmr.data_sel = 2'd3;
    tmr.par_en = 1'b0;
    tmr.stop2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    tmr.enable = 1'b0;
    rst = 1'b0;
    idle(2);
    run(8, 3, 0, 0, 83, -1, 0, 1);
    idle(2);
    run(16, 2, 1, 1, 178, -1, 0, 1);
    idle(2);
    run(5, 3, 0, 0, 53, 15, 32, 1);
    idle(1);
    run(32, 3, 0, 0, 321, -1, 0, 1);
    idle(1);
    run(2, 0, 0, 0, 4, -1, 0, 1);
    idle(2);
    run(8, 3, 0, 0, 34, -1, 0, 1);
    idle(1);
    run(8, 3, 0, 0, 52, -1, 0, 0);
    @(posedge clk);
    #1;
    chk("pre_rst_stb", 32'(tmr.sample_stb), 1);
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    tmr.enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
